// File: rtl/branch_queue.sv
// In-order queue of in-flight branches: allocated at dispatch, resolved out of order
// by the branch ALU, retired in order at commit, where mispredicts redirect and flush.
module branch_queue #(
  parameter int DEPTH = 8,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  input  logic [31:0]     alloc_pc,
  input  logic            alloc_pred_taken,
  input  logic [31:0]     alloc_pred_target,
  output logic            alloc_ready,
  output logic [ID_W-1:0] alloc_id,
  input  logic            res_valid,
  input  logic [ID_W-1:0] res_id,
  input  logic            res_taken,
  input  logic [31:0]     res_target,
  input  logic            commit_valid,
  output logic            commit_ready,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     mispredict_count
);

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
  // valid without ready is ignored, and ready never depends on the same-cycle valid.
  localparam logic [ID_W:0] FULL = (ID_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic [DEPTH-1:0] pred_taken_q;
  logic [DEPTH-1:0] act_taken_q;
  logic [31:0]      pc_q          [DEPTH];
  logic [31:0]      pred_target_q [DEPTH];
  logic [31:0]      act_target_q  [DEPTH];
  logic [ID_W-1:0]  head_q;
  logic [ID_W-1:0]  tail_q;
  logic [ID_W:0]    count_q;

  logic alloc_fire;
  logic commit_fire;
  logic res_fire;
  logic mispredict;

  assign alloc_ready  = (count_q != FULL);
  assign alloc_id     = tail_q;
  assign commit_ready = (count_q != '0) && valid_q[head_q] && resolved_q[head_q];
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign commit_fire  = commit_valid && commit_ready;
  assign res_fire     = res_valid && valid_q[res_id] && !resolved_q[res_id];
  assign mispredict   = (act_taken_q[head_q] != pred_taken_q[head_q]) ||
                        (act_taken_q[head_q] && (act_target_q[head_q] != pred_target_q[head_q]));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      resolved_q       <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (commit_fire && mispredict) begin
        // Everything younger than the head is wrong-path, including same-cycle traffic.
        valid_q          <= '0;
        resolved_q       <= '0;
        head_q           <= '0;
        tail_q           <= '0;
        count_q          <= '0;
        redirect_valid   <= 1'b1;
        redirect_pc      <= act_taken_q[head_q] ? act_target_q[head_q] : pc_q[head_q] + 32'd4;
        mispredict_count <= mispredict_count + 32'd1;
      end else begin
        if (alloc_fire) begin
          valid_q[tail_q]       <= 1'b1;
          resolved_q[tail_q]    <= 1'b0;
          pc_q[tail_q]          <= alloc_pc;
          pred_taken_q[tail_q]  <= alloc_pred_taken;
          pred_target_q[tail_q] <= alloc_pred_target;
          tail_q                <= tail_q + 1'b1;
        end
        if (res_fire) begin
          resolved_q[res_id]   <= 1'b1;
          act_taken_q[res_id]  <= res_taken;
          act_target_q[res_id] <= res_target;
        end
        if (commit_fire) begin
          valid_q[head_q]    <= 1'b0;
          resolved_q[head_q] <= 1'b0;
          head_q             <= head_q + 1'b1;
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_queue.sv
// Directed bench for branch_queue: allocation, out-of-order resolve, in-order commit,
// mispredict redirects, full/wrap behaviour and reset.
module tb_branch_queue;

  localparam int DEPTH = 8;
  localparam int ID_W  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic [31:0]     alloc_pc;
  logic            alloc_pred_taken;
  logic [31:0]     alloc_pred_target;
  logic            alloc_ready;
  logic [ID_W-1:0] alloc_id;
  logic            res_valid;
  logic [ID_W-1:0] res_id;
  logic            res_taken;
  logic [31:0]     res_target;
  logic            commit_valid;
  logic            commit_ready;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [31:0]     mispredict_count;

  logic [31:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  branch_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .res_valid(res_valid), .res_id(res_id), .res_taken(res_taken), .res_target(res_target),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic do_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_target = tgt;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic [ID_W-1:0] id, input logic t, input logic [31:0] tgt);
    res_valid = 1'b1; res_id = id; res_taken = t; res_target = tgt;
    step();
    res_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
  endtask

  // Scoreboard: compare a produced redirect against the oldest expected one.
  task automatic check_redirect(input string tag);
    check({tag, "_valid"}, {31'd0, redirect_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_pc"}, redirect_pc, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred_taken = 1'b0;
    alloc_pred_target = '0; res_valid = 1'b0; res_id = '0; res_taken = 1'b0;
    res_target = '0; commit_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("rst_alloc_id", {29'd0, alloc_id}, 32'd0);
    check("rst_commit_ready", {31'd0, commit_ready}, 32'd0);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_mp_count", mispredict_count, 32'd0);

    // Three not-taken predictions
    do_alloc(32'h100, 1'b0, 32'h0);
    check("alloc_id_1", {29'd0, alloc_id}, 32'd1);
    do_alloc(32'h200, 1'b0, 32'h0);
    check("alloc_id_2", {29'd0, alloc_id}, 32'd2);
    do_alloc(32'h300, 1'b0, 32'h0);
    check("alloc_id_3", {29'd0, alloc_id}, 32'd3);
    check("cr_unresolved", {31'd0, commit_ready}, 32'd0);

    // Out-of-order resolution; head only becomes committable once id0 resolves
    do_resolve(3'd2, 1'b0, 32'h0);
    check("cr_after_res2", {31'd0, commit_ready}, 32'd0);
    do_resolve(3'd0, 1'b0, 32'h0);
    check("cr_after_res0", {31'd0, commit_ready}, 32'd1);
    do_commit();
    check("cr_head1_unres", {31'd0, commit_ready}, 32'd0);
    check("no_redirect_1", {31'd0, redirect_valid}, 32'd0);
    do_commit();
    check("stall_cr", {31'd0, commit_ready}, 32'd0);
    check("stall_alloc_id", {29'd0, alloc_id}, 32'd3);
    do_resolve(3'd1, 1'b0, 32'h0);
    check("cr_after_res1", {31'd0, commit_ready}, 32'd1);
    do_commit();
    check("cr_head2", {31'd0, commit_ready}, 32'd1);
    do_commit();
    check("cr_empty", {31'd0, commit_ready}, 32'd0);
    check("no_redirect_2", {31'd0, redirect_valid}, 32'd0);
    check("mp_count_0", mispredict_count, 32'd0);

    // Direction mispredict with a same-cycle wrong-path allocation
    do_alloc(32'h1000, 1'b1, 32'h2000);
    check("alloc_id_4", {29'd0, alloc_id}, 32'd4);
    do_resolve(3'd3, 1'b0, 32'h0);
    commit_valid = 1'b1;
    alloc_valid = 1'b1; alloc_pc = 32'h5000; alloc_pred_taken = 1'b0; alloc_pred_target = '0;
    exp_q.push_back(32'h1004);
    step();
    commit_valid = 1'b0; alloc_valid = 1'b0;
    check_redirect("redir_dir");
    check("mp_count_1", mispredict_count, 32'd1);
    check("flush_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("flush_alloc_id", {29'd0, alloc_id}, 32'd0);
    step();
    check("redir_pulse_end", {31'd0, redirect_valid}, 32'd0);
    check("redir_pc_hold", redirect_pc, 32'h1004);
    check("dropped_alloc_id", {29'd0, alloc_id}, 32'd0);
    check("dropped_cr", {31'd0, commit_ready}, 32'd0);

    // Correctly predicted taken branch commits silently
    do_alloc(32'h600, 1'b1, 32'h2000);
    do_resolve(3'd0, 1'b1, 32'h2000);
    do_commit();
    check("taken_ok_no_redir", {31'd0, redirect_valid}, 32'd0);
    check("taken_ok_mp_count", mispredict_count, 32'd1);

    // Target mispredict, then a stale resolution of the flushed id
    do_alloc(32'h400, 1'b1, 32'h2000);
    check("alloc_id_tgt", {29'd0, alloc_id}, 32'd2);
    do_resolve(3'd1, 1'b1, 32'h3000);
    exp_q.push_back(32'h3000);
    do_commit();
    check_redirect("redir_tgt");
    check("mp_count_2", mispredict_count, 32'd2);
    do_resolve(3'd1, 1'b1, 32'h2000);
    check("stale_res_cr", {31'd0, commit_ready}, 32'd0);
    check("stale_res_id", {29'd0, alloc_id}, 32'd0);

    // Fill, overflow attempt, free one slot, wrap
    for (int i = 0; i < DEPTH; i++) do_alloc(32'h10 * (i + 1), 1'b0, 32'h0);
    check("full_ready", {31'd0, alloc_ready}, 32'd0);
    check("full_id", {29'd0, alloc_id}, 32'd0);
    do_alloc(32'hdead, 1'b1, 32'hbeef);
    check("overflow_ready", {31'd0, alloc_ready}, 32'd0);
    check("overflow_id", {29'd0, alloc_id}, 32'd0);
    do_resolve(3'd0, 1'b0, 32'h0);
    do_commit();
    check("freed_ready", {31'd0, alloc_ready}, 32'd1);
    check("wrap_id", {29'd0, alloc_id}, 32'd0);
    do_alloc(32'h900, 1'b0, 32'h0);
    check("wrap_id_next", {29'd0, alloc_id}, 32'd1);
    check("refull_ready", {31'd0, alloc_ready}, 32'd0);
    do_resolve(3'd1, 1'b1, 32'h7777);
    exp_q.push_back(32'h7777);
    do_commit();
    check_redirect("redir_wrap");
    check("mp_count_3", mispredict_count, 32'd3);

    // Reset with resolved entries in flight
    for (int i = 0; i < 4; i++) do_alloc(32'h40 * (i + 1), 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) do_resolve(3'(i), 1'b0, 32'h0);
    check("pre_rst_cr", {31'd0, commit_ready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("rst2_alloc_id", {29'd0, alloc_id}, 32'd0);
    check("rst2_cr", {31'd0, commit_ready}, 32'd0);
    check("rst2_mp_count", mispredict_count, 32'd0);
    check("rst2_redirect_pc", redirect_pc, 32'd0);

    // Reset during a redirect pulse
    do_alloc(32'h900, 1'b0, 32'h0);
    do_resolve(3'd0, 1'b1, 32'hA000);
    exp_q.push_back(32'hA000);
    do_commit();
    check_redirect("redir_pre_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst3_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst3_redirect_pc", redirect_pc, 32'd0);
    check("rst3_mp_count", mispredict_count, 32'd0);
    check("rst3_alloc_id", {29'd0, alloc_id}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
